// File: rtl/fifo_pkg.sv
// Shared defaults and pointer sizing for the synchronous FIFO family.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 8;

  // Pointer carries one extra wrap bit above the memory address bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port and one read port that is
// either registered (standard mode) or combinational (first-word-fall-through).
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int FWFT   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // rd_en is a load strobe in standard mode and a head-valid qualifier in
  // FWFT mode; gating keeps stale or never-written words off rdata.
  if (FWFT != 0) begin : g_fwft
    assign rdata = (rst_n && rd_en) ? mem[raddr] : '0;
  end else begin : g_std
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata <= '0;
      end else if (rd_en) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO: pointer/flag logic here, storage in fifo_ram.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      winc,
  input  logic [DATA_W-1:0]         w_data,
  input  logic                      rinc,
  input  logic                      clr_err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      wfull,
  output logic                      rempty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_T     = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_T     = PTR_W'(AE_THRESH);

  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W-1:0] wptr_nxt, rptr_nxt, count_nxt;
  logic             w_acc, r_acc;

  // Handshake: winc/rinc are single-cycle requests sampled on the rising edge.
  // A request is accepted only when the registered wfull/rempty flag permits it
  // that cycle; a refused request changes nothing except the sticky error flag.
  assign w_acc = winc & ~wfull;
  assign r_acc = rinc & ~rempty;

  assign wptr_nxt  = w_acc ? wptr + PTR_W'(1) : wptr;
  assign rptr_nxt  = r_acc ? rptr + PTR_W'(1) : rptr;
  assign count_nxt = wptr_nxt - rptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      rempty       <= 1'b1;
      wfull        <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      count        <= count_nxt;
      rempty       <= (count_nxt == '0);
      wfull        <= (count_nxt == FULL_CNT);
      almost_full  <= (count_nxt >= AF_T);
      almost_empty <= (count_nxt <= AE_T);
      // Setting wins over clr_err in the same cycle.
      overflow     <= (winc & wfull) | (overflow & ~clr_err);
      underflow    <= (rinc & rempty) | (underflow & ~clr_err);
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .FWFT   (FWFT)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (w_acc),
    .waddr  (wptr[AW-1:0]),
    .wdata  (w_data),
    .rd_en  ((FWFT != 0) ? ~rempty : r_acc),
    .raddr  (rptr[AW-1:0]),
    .rdata  (rdata)
  );

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo (standard and FWFT instances).
module tb_param_sync_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       winc = 1'b0, rinc = 1'b0, clr_err = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic [7:0] rdata;
  logic       wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  logic       f_winc = 1'b0, f_rinc = 1'b0;
  logic [7:0] f_wdata = 8'h00;
  logic [7:0] f_rdata;
  logic       f_wfull, f_rempty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] f_count;

  // clock / reset
  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .w_data(w_data), .rinc(rinc),
    .clr_err(clr_err), .rdata(rdata), .wfull(wfull), .rempty(rempty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  param_sync_fifo #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .winc(f_winc), .w_data(f_wdata), .rinc(f_rinc),
    .clr_err(1'b0), .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  int n_chk = 0;
  int n_pass = 0;

  // reference model: contents as a queue, sticky flags, expected read data
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         m_ovf = 1'b0, m_unf = 1'b0, rd_pend = 1'b0;
  logic [7:0] m_rd = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    rd_pend = 1'b0;
    m_rd = 8'h00;
  endtask

  task automatic model_step(input bit w, input bit r, input logic [7:0] d, input bit c);
    bit full, empty;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    m_ovf = (w && full) || (m_ovf && !c);
    m_unf = (r && empty) || (m_unf && !c);
    rd_pend = 1'b0;
    if (r && !empty) begin
      m_rd = mq.pop_front();
      exp_q.push_back(m_rd);
      rd_pend = 1'b1;
    end
    if (w && !full) mq.push_back(d);
  endtask

  // driver: one clock of stimulus, model advanced on the same edge
  task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit c);
    @(negedge clk);
    winc = w;
    rinc = r;
    w_data = d;
    clr_err = c;
    @(posedge clk);
    model_step(w, r, d, c);
  endtask

  // monitor: compares flags every cycle, pops expected data on each read
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(mq.size()));
    chk("rempty", 32'(rempty), 32'(mq.size() == 0));
    chk("wfull", 32'(wfull), 32'(mq.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - 2));
    chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL rdata_pop: read accepted but no expected word queued at %0t", $time);
      end else begin
        chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
      end
    end else begin
      chk("rdata_hold", 32'(rdata), 32'(m_rd));
    end
  end

  initial begin
    // reset, then underflow probe and clear
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);

    // fill 1..8, overflow attempt, drain in order
    for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i), 0);
    cyc(1, 0, 8'd99, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);

    // steady state at 4 entries with simultaneous traffic (pointers wrap)
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'($urandom_range(255, 0)), 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 8'($urandom_range(255, 0)), 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00, 0);

    // both requests while full, then while empty
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'($urandom_range(255, 0)), 0);
    cyc(1, 1, 8'h77, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);
    cyc(1, 1, 8'h11, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);

    // randomized traffic alternating write-heavy and read-heavy phases
    for (int i = 0; i < 300; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 80 : 25;
      cyc($urandom_range(99, 0) < wp, $urandom_range(99, 0) < (105 - wp),
          8'($urandom_range(255, 0)), $urandom_range(19, 0) == 0);
    end

    // asynchronous reset at count 5 with underflow set
    for (int i = 0; i < 9; i++) cyc(0, 1, 8'h00, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h40 + i), 0);
    @(negedge clk);
    winc = 1'b1;
    w_data = 8'hEE;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_almost_full", 32'(almost_full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_f_rempty", 32'(f_rempty), 1);
    @(negedge clk);
    winc = 1'b0;
    rst_n = 1'b1;
    cyc(1, 0, 8'h3C, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);

    // first-word-fall-through instance
    @(negedge clk);
    f_winc = 1'b1;
    f_wdata = 8'hA5;
    @(negedge clk);
    chk("fwft_head_a5", 32'(f_rdata), 32'h00A5);
    chk("fwft_not_empty", 32'(f_rempty), 0);
    chk("fwft_count1", 32'(f_count), 1);
    f_wdata = 8'h5A;
    @(negedge clk);
    chk("fwft_head_hold", 32'(f_rdata), 32'h00A5);
    chk("fwft_count2", 32'(f_count), 2);
    f_winc = 1'b0;
    f_rinc = 1'b1;
    @(negedge clk);
    chk("fwft_head_5a", 32'(f_rdata), 32'h005A);
    chk("fwft_count_pop", 32'(f_count), 1);
    @(negedge clk);
    f_rinc = 1'b0;
    chk("fwft_empty", 32'(f_rempty), 1);
    chk("fwft_count0", 32'(f_count), 0);
    chk("fwft_no_underflow", 32'(f_unf), 0);

    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
